// File: rtl/sync_down_counter_nbit_pkg.sv
// sync_down_counter_pkg: shared constants for the loadable down counter.
//   ST_W             width of the control-state register
//   ST_IDLE/RUN/DONE control-state encodings
package sync_down_counter_pkg;
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/sync_down_counter_nbit_if.sv
// sync_down_counter_nbit_if: control and status bundle of the down counter.
//   load/load_value/start/stop/auto_reload/count_en  controls into the counter
//   count/tc/running/done/zero                        status out of the counter
//   master: the controlling side; slave: the counter itself
interface sync_down_counter_nbit_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic             count_en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    logic             done;
    logic             zero;
    modport master (
        output load, load_value, start, stop, auto_reload, count_en,
        input  count, tc, running, done, zero
    );
    modport slave (
        input  load, load_value, start, stop, auto_reload, count_en,
        output count, tc, running, done, zero
    );
endinterface

// File: rtl/sync_down_counter_nbit_tff_ld_cell.sv
// tff_ld_cell: one counter bit, a T flip-flop with synchronous load.
//   clk, reset_n  clock and asynchronous active-low reset
//   ld, d         load strobe and value; load wins over toggle
//   t             toggle enable
//   q             stored bit
module tff_ld_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            q <= 1'b0;
        else if (ld)
            q <= d;
        else if (t)
            q <= ~q;
endmodule

// File: rtl/sync_down_counter_nbit.sv
// sync_down_counter_nbit: loadable down counter / interval timer with one-shot
// or auto-reload operation and a registered terminal-count pulse.
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           slave side of sync_down_counter_nbit_if (controls in, status out)
module sync_down_counter_nbit
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    reset_n,
    sync_down_counter_nbit_if.slave bus
);
    logic [ST_W-1:0]  state, state_nxt;
    logic [WIDTH-1:0] count, reload_reg, d, t;
    logic [WIDTH:0]   lz;
    logic             zero, tick, dec, term, ld, tc_q, running, done;

    // A tick is a qualified count step; load and stop both pre-empt it.
    assign tick = (state == ST_RUN) & bus.count_en & ~bus.load & ~bus.stop;
    assign dec  = tick & ~zero;
    assign term = tick & zero;
    // Cells load on an explicit load, on restart from DONE, or on auto-reload.
    assign ld   = bus.load | (bus.start & (state == ST_DONE)) | (term & bus.auto_reload);
    assign d    = bus.load ? bus.load_value : reload_reg;

    // lz[i] is high when every bit below i is zero: bit i toggles on borrow.
    // lz[WIDTH] therefore doubles as the count==0 flag.
    assign lz[0] = 1'b1;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign lz[i+1] = lz[i] & ~count[i];
            assign t[i]    = dec & lz[i];
            tff_ld_cell u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .ld      (ld),
                .d       (d[i]),
                .t       (t[i]),
                .q       (count[i])
            );
        end
    endgenerate
    assign zero = lz[WIDTH];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= ST_IDLE;
            reload_reg <= '0;
            tc_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            tc_q  <= term;
            if (bus.load)
                reload_reg <= bus.load_value;
        end

    always_comb begin
        state_nxt = state;
        if (bus.load)
            state_nxt = (state == ST_DONE) ? ST_IDLE : state;
        else if (bus.stop && state == ST_RUN)
            state_nxt = ST_IDLE;
        else if (bus.start && state != ST_RUN)
            state_nxt = ST_RUN;
        else if (term && !bus.auto_reload)
            state_nxt = ST_DONE;
    end

    always_comb begin
        running = (state == ST_RUN);
        done    = (state == ST_DONE);
    end

    assign bus.count   = count;
    assign bus.tc      = tc_q;
    assign bus.running = running;
    assign bus.done    = done;
    assign bus.zero    = zero;
endmodule
